crc_dma_ctrl: RTL and testbench

DMA sequencer that streams a block of 32-bit words from SoC RAM into the crc32 accelerator without CPU involvement, then exposes the final CRC. It sits on the picorv32 native bus as a memory-mapped slave (control registers) and as a read-only bus master (RAM fetch). It is the only driver of the crc32 valid/wdata/addr_bit inputs when instantiated. Completion is reported by a status bit and an optional level interrupt.

---
 rtl/crc_dma_pkg.sv | 31 +++
 rtl/crc_dma_regs.sv | 99 +++++++++
 rtl/crc_dma_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_crc_dma_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_dma_pkg.sv
// Shared definitions for the CRC DMA sequencer: register offsets, bit indices, FSM states.
// Ports: none (package only).
// Imported by crc_dma_regs and crc_dma_ctrl.
package crc_dma_pkg;

    // Register index = s_addr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_SRC    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_SEED   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_RESULT = 3'd5;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    // STATUS bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_FETCH = 3'd2,
        ST_FEED  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/crc_dma_regs.sv
// Register file and slave decode for the CRC DMA sequencer.
// Ports: slave bus (s_*), config outputs (src/len/seed/irq_en), command pulses (start/abort/w1c),
//        status inputs (busy/done/result) for readback. Zero-wait: s_ready_o = s_valid_i.
module crc_dma_regs
    import crc_dma_pkg::*;
#(
    parameter int          LEN_W = 16,
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_i,
    input  logic [4:0]       s_addr_i,
    input  logic [31:0]      s_wdata_i,
    input  logic [3:0]       s_wstrb_i,
    output logic             s_ready_o,
    output logic [31:0]      s_rdata_o,
    input  logic             busy_i,
    input  logic             done_i,
    input  logic [31:0]      result_i,
    output logic [31:0]      src_o,
    output logic [LEN_W-1:0] len_o,
    output logic [31:0]      seed_o,
    output logic             irq_en_o,
    output logic             start_o,
    output logic             abort_o,
    output logic             w1c_o
);

    logic [2:0]       reg_sel;
    logic             wr;
    logic [31:0]      src_q, src_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      seed_q, seed_d;
    logic             irq_en_q, irq_en_d;
    logic [1:0]       unused_ok;

    assign reg_sel   = s_addr_i[4:2];
    assign unused_ok = s_addr_i[1:0];
    // Any nonzero strobe is treated as a full-word write
    assign wr        = s_valid_i && (s_wstrb_i != 4'b0);
    assign s_ready_o = s_valid_i;

    // Command pulses; start is only meaningful when the sequencer is idle
    assign start_o = wr && (reg_sel == REG_CTRL) && s_wdata_i[CTRL_START] && !busy_i;
    assign abort_o = wr && (reg_sel == REG_CTRL) && s_wdata_i[CTRL_ABORT];
    assign w1c_o   = wr && (reg_sel == REG_STATUS) && s_wdata_i[STAT_DONE];

    always_comb begin
        src_d    = src_q;
        len_d    = len_q;
        seed_d   = seed_q;
        irq_en_d = irq_en_q;
        if (wr) begin
            case (reg_sel)
                REG_CTRL: irq_en_d = s_wdata_i[CTRL_IRQ_EN];
                REG_SRC:  if (!busy_i) src_d  = {s_wdata_i[31:2], 2'b00};
                REG_LEN:  if (!busy_i) len_d  = s_wdata_i[LEN_W-1:0];
                REG_SEED: if (!busy_i) seed_d = s_wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= 32'h0;
            len_q    <= '0;
            seed_q   <= SEED;
            irq_en_q <= 1'b0;
        end else begin
            src_q    <= src_d;
            len_q    <= len_d;
            seed_q   <= seed_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        s_rdata_o = 32'h0;
        if (s_valid_i) begin
            case (reg_sel)
                REG_CTRL:   s_rdata_o = {30'b0, irq_en_q, 1'b0};
                REG_SRC:    s_rdata_o = src_q;
                REG_LEN:    s_rdata_o = 32'(len_q);
                REG_SEED:   s_rdata_o = seed_q;
                REG_STATUS: s_rdata_o = {30'b0, done_i, busy_i};
                REG_RESULT: s_rdata_o = result_i;
                default:    s_rdata_o = 32'h0;
            endcase
        end
    end

    assign src_o    = src_q;
    assign len_o    = len_q;
    assign seed_o   = seed_q;
    assign irq_en_o = irq_en_q;

endmodule

// File: rtl/crc_dma_ctrl.sv
// DMA sequencer streaming a block of RAM words into the crc32 accelerator, then latching the CRC.
// Ports: slave register bus (s_*), read-only RAM master (m_*), crc32 write port (crc_*), level irq.
// All master/crc outputs are registered; requests are held until their ready is sampled high.
module crc_dma_ctrl
    import crc_dma_pkg::*;
#(
    parameter int          LEN_W = 16,
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [4:0]  s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_ready,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        crc_valid,
    output logic [31:0] crc_wdata,
    output logic        crc_addr_bit,
    input  logic        crc_ready,
    input  logic [31:0] crc_rdata,
    output logic        irq
);

    state_t           state_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    logic             abort_q;
    logic             done_q;
    logic             irq_q;
    logic [31:0]      result_q;
    logic             m_valid_q;
    logic [31:0]      m_addr_q;
    logic             crc_valid_q;
    logic [31:0]      crc_wdata_q;
    logic             crc_addr_bit_q;

    logic             busy;
    logic             aborting;
    logic [31:0]      src;
    logic [LEN_W-1:0] len;
    logic [31:0]      seed;
    logic             irq_en;
    logic             start_pulse;
    logic             abort_pulse;
    logic             w1c_pulse;

    assign busy = (state_q != ST_IDLE);
    // An abort seen in the same cycle as a handshake still lets that handshake finish
    assign aborting = abort_q || abort_pulse;

    crc_dma_regs #(
        .LEN_W (LEN_W),
        .SEED  (SEED)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .s_valid_i (s_valid),
        .s_addr_i  (s_addr),
        .s_wdata_i (s_wdata),
        .s_wstrb_i (s_wstrb),
        .s_ready_o (s_ready),
        .s_rdata_o (s_rdata),
        .busy_i    (busy),
        .done_i    (done_q),
        .result_i  (result_q),
        .src_o     (src),
        .len_o     (len),
        .seed_o    (seed),
        .irq_en_o  (irq_en),
        .start_o   (start_pulse),
        .abort_o   (abort_pulse),
        .w1c_o     (w1c_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= 32'h0;
            rem_q          <= '0;
            abort_q        <= 1'b0;
            done_q         <= 1'b0;
            irq_q          <= 1'b0;
            result_q       <= 32'h0;
            m_valid_q      <= 1'b0;
            m_addr_q       <= 32'h0;
            crc_valid_q    <= 1'b0;
            crc_wdata_q    <= 32'h0;
            crc_addr_bit_q <= 1'b0;
        end else begin
            // W1C first so a start or completion later in this block takes priority
            if (w1c_pulse) begin
                done_q <= 1'b0;
                irq_q  <= 1'b0;
            end
            if (abort_pulse && busy) abort_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (start_pulse) begin
                        addr_q         <= src;
                        rem_q          <= len;
                        done_q         <= 1'b0;
                        irq_q          <= 1'b0;
                        crc_valid_q    <= 1'b1;
                        crc_addr_bit_q <= 1'b1;
                        crc_wdata_q    <= seed;
                        state_q        <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    if (crc_ready) begin
                        crc_valid_q    <= 1'b0;
                        crc_addr_bit_q <= 1'b0;
                        if (aborting) begin
                            state_q <= ST_IDLE;
                        end else if (rem_q != '0) begin
                            m_valid_q <= 1'b1;
                            m_addr_q  <= addr_q;
                            state_q   <= ST_FETCH;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        addr_q    <= addr_q + 32'd4;
                        if (aborting) begin
                            state_q <= ST_IDLE;
                        end else begin
                            crc_valid_q    <= 1'b1;
                            crc_addr_bit_q <= 1'b0;
                            crc_wdata_q    <= m_rdata;
                            state_q        <= ST_FEED;
                        end
                    end
                end
                ST_FEED: begin
                    if (crc_ready) begin
                        crc_valid_q <= 1'b0;
                        rem_q       <= rem_q - LEN_W'(1);
                        if (aborting) begin
                            state_q <= ST_IDLE;
                        end else if (rem_q != LEN_W'(1)) begin
                            m_valid_q <= 1'b1;
                            m_addr_q  <= addr_q;
                            state_q   <= ST_FETCH;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // No handshake is open here, so an abort just skips completion
                    if (!aborting) begin
                        result_q <= crc_rdata;
                        done_q   <= 1'b1;
                        irq_q    <= irq_en;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_valid      = m_valid_q;
    assign m_addr       = m_addr_q;
    assign crc_valid    = crc_valid_q;
    assign crc_wdata    = crc_wdata_q;
    assign crc_addr_bit = crc_addr_bit_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_crc_dma_ctrl.sv
module tb_crc_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        crc_valid;
    logic [31:0] crc_wdata;
    logic        crc_addr_bit;
    logic        crc_ready;
    logic [31:0] crc_rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    crc_dma_ctrl #(.LEN_W(16), .SEED(32'hFFFF_FFFF)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready), .m_rdata(m_rdata),
        .crc_valid(crc_valid), .crc_wdata(crc_wdata), .crc_addr_bit(crc_addr_bit),
        .crc_ready(crc_ready), .crc_rdata(crc_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- slave stubs ----------------
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            32'h0000_0108: return 32'h4444_4444;
            32'hFFFF_FFFC: return 32'h0F0F_0F0F;
            32'h0000_0000: return 32'h00F0_F0F0;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    int m_stall = 0, c_stall = 0, m_cnt = 0, c_cnt = 0;
    logic [31:0] acc = 32'h0;

    assign m_ready   = m_valid && (m_cnt >= m_stall);
    assign m_rdata   = mem_rd(m_addr);
    assign crc_ready = crc_valid && (c_cnt >= c_stall);
    assign crc_rdata = acc;

    // XOR-accumulator stand-in for crc32
    always @(posedge clk) begin
        m_cnt <= (m_valid && !m_ready) ? m_cnt + 1 : 0;
        c_cnt <= (crc_valid && !crc_ready) ? c_cnt + 1 : 0;
        if (reset) acc <= 32'h0;
        else if (crc_valid && crc_ready) acc <= crc_addr_bit ? crc_wdata : (acc ^ crc_wdata);
    end

    // ---------------- monitor (samples mid-cycle) ----------------
    logic [31:0] fetch_q[$];
    int seed_wr = 0, data_wr = 0, stab_err = 0;
    logic pm_hold = 1'b0, pc_hold = 1'b0, pc_bit = 1'b0;
    logic [31:0] pm_addr = 32'h0, pc_wdata = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            pm_hold = 1'b0;
            pc_hold = 1'b0;
        end else begin
            if (pm_hold && (m_valid !== 1'b1 || m_addr !== pm_addr)) stab_err++;
            if (pc_hold && (crc_valid !== 1'b1 || crc_wdata !== pc_wdata || crc_addr_bit !== pc_bit))
                stab_err++;
            if (m_valid && m_ready) fetch_q.push_back(m_addr);
            if (crc_valid && crc_ready) begin
                if (crc_addr_bit) seed_wr++;
                else data_wr++;
            end
            pm_hold  = m_valid && !m_ready;
            pm_addr  = m_addr;
            pc_hold  = crc_valid && !crc_ready;
            pc_wdata = crc_wdata;
            pc_bit   = crc_addr_bit;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = 4'hF;
        @(posedge clk); #1;
        s_valid = 1'b0; s_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wstrb = 4'h0;
        #1 d = s_rdata;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic clear_mon();
        fetch_q.delete();
        seed_wr = 0; data_wr = 0; stab_err = 0;
    endtask

    // One STATUS read per cycle; done_k = cycles after start edge when done first seen
    task automatic run_wait(input int maxc, output int done_k, output int busy_n);
        logic [31:0] d;
        done_k = -1; busy_n = 0;
        for (int k = 0; k < maxc; k++) begin
            bus_read(5'h10, d);
            if (d[0]) busy_n++;
            if (d[1]) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic setup(input logic [31:0] src, input logic [31:0] len, input logic [31:0] seed);
        bus_write(5'h04, src);
        bus_write(5'h08, len);
        bus_write(5'h0C, seed);
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];
    logic [31:0] rd;
    logic [31:0] exp_a[3];
    int k, b;
    int found;

    initial begin
        vt[0] = '{5'h04, 1'b1, 32'h1234_5677, 32'h1234_5674};
        vt[1] = '{5'h08, 1'b1, 32'h000A_BCDE, 32'h0000_BCDE};
        vt[2] = '{5'h0C, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vt[3] = '{5'h00, 1'b1, 32'h0000_0002, 32'h0000_0002};
        vt[4] = '{5'h00, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vt[5] = '{5'h18, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[6] = '{5'h1C, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{5'h10, 1'b0, 32'h0000_0000, 32'h0000_0000};

        s_valid = 1'b0; s_addr = 5'h0; s_wdata = 32'h0; s_wstrb = 4'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        check("rst_m_valid", {31'b0, m_valid}, 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_crc_valid", {31'b0, crc_valid}, 32'h0);
        check("rst_crc_wdata", crc_wdata, 32'h0);
        check("rst_crc_addr_bit", {31'b0, crc_addr_bit}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_s_ready", {31'b0, s_ready}, 32'h0);
        check("rst_s_rdata", s_rdata, 32'h0);
        bus_read(5'h0C, rd); check("rst_seed", rd, 32'hFFFF_FFFF);
        bus_read(5'h14, rd); check("rst_result", rd, 32'h0);

        // ---- register table ----
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].wdata);
            bus_read(vt[i].addr, rd);
            check($sformatf("reg_vec%0d", i), rd, vt[i].exp);
        end

        // ---- basic 3-word run, zero wait ----
        exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108;
        setup(32'h100, 32'd3, 32'h0);
        clear_mon();
        bus_write(5'h00, 32'h1);
        run_wait(40, k, b);
        check("run3_latency", k, 32'd8);
        check("run3_nfetch", fetch_q.size(), 32'd3);
        if (fetch_q.size() == 3)
            for (int i = 0; i < 3; i++) check($sformatf("run3_addr%0d", i), fetch_q[i], exp_a[i]);
        check("run3_seed_wr", seed_wr, 32'd1);
        check("run3_data_wr", data_wr, 32'd3);
        bus_read(5'h14, rd); check("run3_result", rd, 32'h7777_7777);

        // ---- LEN=0: seed only ----
        setup(32'h100, 32'd0, 32'hA5A5_A5A5);
        clear_mon();
        bus_write(5'h00, 32'h1);
        run_wait(40, k, b);
        check("len0_latency", k, 32'd2);
        check("len0_busy_cycles", b, 32'd2);
        check("len0_nfetch", fetch_q.size(), 32'd0);
        check("len0_seed_wr", seed_wr, 32'd1);
        bus_read(5'h14, rd); check("len0_result", rd, 32'hA5A5_A5A5);

        // ---- stalled slaves ----
        setup(32'h100, 32'd3, 32'h0);
        m_stall = 3; c_stall = 5;
        clear_mon();
        bus_write(5'h00, 32'h1);
        run_wait(200, k, b);
        check("stall_latency", k, 32'd37);
        check("stall_stable_errs", stab_err, 32'd0);
        check("stall_nfetch", fetch_q.size(), 32'd3);
        bus_read(5'h14, rd); check("stall_result", rd, 32'h7777_7777);
        m_stall = 0; c_stall = 0;

        // ---- irq, busy lock, W1C ----
        bus_write(5'h00, 32'h2);
        setup(32'h100, 32'd2, 32'h0);
        clear_mon();
        bus_write(5'h00, 32'h3);
        bus_write(5'h08, 32'd5);
        bus_read(5'h08, rd); check("busy_len_lock", rd, 32'd2);
        run_wait(40, k, b);
        check("irq_done_seen", {31'b0, k >= 0}, 32'h1);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_read(5'h14, rd); check("irq_result", rd, 32'h3333_3333);
        bus_write(5'h00, 32'h0);
        check("irq_holds_after_en_clr", {31'b0, irq}, 32'h1);
        bus_write(5'h10, 32'h2);
        check("irq_w1c", {31'b0, irq}, 32'h0);
        bus_read(5'h10, rd); check("status_w1c", rd, 32'h0);

        // ---- abort during stalled FETCH ----
        setup(32'h100, 32'd3, 32'h0);
        m_stall = 6;
        clear_mon();
        bus_write(5'h00, 32'h1);
        @(posedge clk);
        bus_write(5'h00, 32'h4);
        check("abort_m_valid_held", {31'b0, m_valid}, 32'h1);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            bus_read(5'h10, rd);
            if (!rd[0]) begin
                found = 1;
                break;
            end
        end
        check("abort_returns_idle", found, 32'd1);
        check("abort_status", rd, 32'h0);
        check("abort_nfetch", fetch_q.size(), 32'd1);
        check("abort_data_wr", data_wr, 32'd0);
        check("abort_stable_errs", stab_err, 32'd0);
        bus_read(5'h14, rd); check("abort_result_kept", rd, 32'h3333_3333);
        m_stall = 0;

        // ---- address wrap ----
        setup(32'hFFFF_FFFC, 32'd2, 32'h0);
        clear_mon();
        bus_write(5'h00, 32'h1);
        run_wait(40, k, b);
        check("wrap_latency", k, 32'd6);
        check("wrap_nfetch", fetch_q.size(), 32'd2);
        if (fetch_q.size() == 2) begin
            check("wrap_addr0", fetch_q[0], 32'hFFFF_FFFC);
            check("wrap_addr1", fetch_q[1], 32'h0000_0000);
        end
        bus_read(5'h14, rd); check("wrap_result", rd, 32'h0FFF_FFFF);

        // ---- reset mid-FEED ----
        setup(32'h100, 32'd3, 32'h0);
        c_stall = 4;
        bus_write(5'h00, 32'h1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (crc_valid && !crc_addr_bit) begin
                found = 1;
                break;
            end
        end
        check("midfeed_reached", found, 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_m_valid", {31'b0, m_valid}, 32'h0);
        check("mrst_m_addr", m_addr, 32'h0);
        check("mrst_crc_valid", {31'b0, crc_valid}, 32'h0);
        check("mrst_crc_wdata", crc_wdata, 32'h0);
        check("mrst_crc_addr_bit", {31'b0, crc_addr_bit}, 32'h0);
        check("mrst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        c_stall = 0;
        bus_read(5'h0C, rd); check("mrst_seed", rd, 32'hFFFF_FFFF);
        bus_read(5'h10, rd); check("mrst_status", rd, 32'h0);
        bus_read(5'h14, rd); check("mrst_result", rd, 32'h0);
        bus_read(5'h08, rd); check("mrst_len", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
